// File: rtl/l2_line_responder_if.sv
// L1-Icache line request / memory word-read bundle for the L2 line responder.
interface l2_line_responder_if #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int block_size    = 8
);
  localparam int offset_width = $clog2(data_width*block_size/8);
  localparam int line_width   = data_width*block_size;

  logic [address_width-offset_width-1:0] ADDR_FROM_L1;
  logic                                  ADDR_FROM_L1_VALID;
  logic [line_width-1:0]                 DATA_TO_L1;
  logic                                  DATA_TO_L1_VALID;
  logic                                  BUSY;
  logic                                  MEM_RD_REQ;
  logic [address_width-1:0]              MEM_RD_ADDR;
  logic                                  MEM_RD_ACK;
  logic [data_width-1:0]                 MEM_RD_DATA;

  modport slave (
    input  ADDR_FROM_L1,
    input  ADDR_FROM_L1_VALID,
    input  MEM_RD_ACK,
    input  MEM_RD_DATA,
    output DATA_TO_L1,
    output DATA_TO_L1_VALID,
    output BUSY,
    output MEM_RD_REQ,
    output MEM_RD_ADDR
  );

  modport master (
    output ADDR_FROM_L1,
    output ADDR_FROM_L1_VALID,
    output MEM_RD_ACK,
    output MEM_RD_DATA,
    input  DATA_TO_L1,
    input  DATA_TO_L1_VALID,
    input  BUSY,
    input  MEM_RD_REQ,
    input  MEM_RD_ADDR
  );
endinterface

// File: rtl/l2_line_responder.sv
// L2 line-fill responder: fetches block_size words and returns one packed line.
// Optional L2_LINE_BUFFER_EN: replay the last filled line without a memory fill.
module l2_line_responder #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int block_size    = 8
) (
  input logic              CLK,
  input logic              RSTN,
  l2_line_responder_if.slave bus
);
  localparam int offset_width = $clog2(data_width*block_size/8);
  localparam int beat_width   = $clog2(block_size);
  localparam int byte_width   = $clog2(data_width/8);
  localparam int la_width     = address_width-offset_width;
  localparam int line_width   = data_width*block_size;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [beat_width-1:0] LAST = beat_width'(block_size-1);

  logic [1:0]               state_q, state_d;
  logic [beat_width-1:0]    beat_q, beat_d;
  logic [la_width-1:0]      laddr_q, laddr_d;
  logic [line_width-1:0]    line_q, line_d;
  logic                     vld_q, vld_d;
  logic                     req_q, req_d;
  logic [address_width-1:0] maddr_q, maddr_d;
  logic                     hit;

`ifdef L2_LINE_BUFFER_EN
  logic                buf_vld_q, buf_vld_d;
  logic [la_width-1:0] buf_addr_q, buf_addr_d;

  assign hit = buf_vld_q && (buf_addr_q == bus.ADDR_FROM_L1);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    laddr_d = laddr_q;
    line_d  = line_q;
    vld_d   = vld_q;
    req_d   = req_q;
    maddr_d = maddr_q;
`ifdef L2_LINE_BUFFER_EN
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.ADDR_FROM_L1_VALID) begin
          if (hit) begin
            state_d = RESP;
            vld_d   = 1'b1;
          end else begin
            state_d = FETCH;
            laddr_d = bus.ADDR_FROM_L1;
            beat_d  = '0;
            req_d   = 1'b1;
            maddr_d = {bus.ADDR_FROM_L1,
                       {beat_width{1'b0}},
                       {byte_width{1'b0}}};
          end
        end
      end
      (state_q == FETCH): begin
        if (bus.MEM_RD_ACK) begin
          line_d[beat_q*data_width +: data_width] = bus.MEM_RD_DATA;
          if (beat_q == LAST) begin
            beat_d  = '0;
            req_d   = 1'b0;
            state_d = RESP;
            vld_d   = 1'b1;
`ifdef L2_LINE_BUFFER_EN
            buf_vld_d  = 1'b1;
            buf_addr_d = laddr_q;
`endif
          end else begin
            beat_d  = beat_q + 1'b1;
            maddr_d = {laddr_q,
                       beat_q + 1'b1,
                       {byte_width{1'b0}}};
          end
        end
      end
      (state_q == RESP): begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      beat_q  <= '0;
      laddr_q <= '0;
      line_q  <= '0;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      laddr_q <= laddr_d;
      line_q  <= line_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
    end
  end

`ifdef L2_LINE_BUFFER_EN
  // Buffer is only ever invalidated by reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
    end
  end
`endif

  assign bus.DATA_TO_L1       = line_q;
  assign bus.DATA_TO_L1_VALID = vld_q;
  assign bus.BUSY             = (state_q != IDLE);
  assign bus.MEM_RD_REQ       = req_q;
  assign bus.MEM_RD_ADDR      = maddr_q;
endmodule

// File: tb/tb_l2_line_responder.sv
// Scoreboard bench for l2_line_responder: memory model, request driver, monitor.
module tb_l2_line_responder;
  logic CLK = 1'b0;
  logic RSTN = 1'b1;
  always #5 CLK = ~CLK;

  l2_line_responder_if bus ();

  l2_line_responder dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_addr[$];
  logic [255:0] exp_line[$];
  logic [255:0] last_line = '0;
  int delay = 0;
  bit spur  = 1'b0;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(4*i);
    return l;
  endfunction

  // Memory: acks after `delay` stall cycles, returns the address as data.
  initial begin
    int cnt;
    cnt = 0;
    bus.MEM_RD_ACK  = 1'b0;
    bus.MEM_RD_DATA = '0;
    forever begin
      @(negedge CLK);
      if (spur) begin
        bus.MEM_RD_ACK  = 1'b1;
        bus.MEM_RD_DATA = 32'hDEADBEEF;
      end else if (bus.MEM_RD_REQ) begin
        if (cnt >= delay) begin
          bus.MEM_RD_ACK  = 1'b1;
          bus.MEM_RD_DATA = bus.MEM_RD_ADDR;
          cnt = 0;
        end else begin
          bus.MEM_RD_ACK = 1'b0;
          cnt++;
        end
      end else begin
        bus.MEM_RD_ACK = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    logic        pv;
    logic [31:0] pa;
    logic        pvld;
    pv = 1'b0; pa = '0; pvld = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (RSTN) begin
        if (pv && bus.MEM_RD_REQ)
          chk("req_addr_stable", bus.MEM_RD_ADDR, pa);
        if (bus.MEM_RD_REQ && bus.MEM_RD_ACK) begin
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req addr %h", bus.MEM_RD_ADDR);
          end else begin
            chk("rd_addr", bus.MEM_RD_ADDR, exp_addr.pop_front());
          end
        end
        if (bus.DATA_TO_L1_VALID) begin
          if (pvld) begin
            checks++; errors++;
            $display("FAIL valid_width got 2+ cycles want 1");
          end
          if (exp_line.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid line %h", bus.DATA_TO_L1);
          end else begin
            chk("line", bus.DATA_TO_L1, exp_line.pop_front());
          end
        end
        pv   = bus.MEM_RD_REQ && !bus.MEM_RD_ACK;
        pa   = bus.MEM_RD_ADDR;
        pvld = bus.DATA_TO_L1_VALID;
      end else begin
        pv   = 1'b0;
        pvld = 1'b0;
      end
    end
  end

  task automatic request(input logic [26:0] la);
    @(negedge CLK);
    bus.ADDR_FROM_L1       = la;
    bus.ADDR_FROM_L1_VALID = 1'b1;
    @(negedge CLK);
    bus.ADDR_FROM_L1_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    for (k = 1; k <= 100; k++) begin
      #2;
      if (bus.DATA_TO_L1_VALID) break;
      @(negedge CLK);
    end
  endtask

  task automatic fill(input logic [26:0] la, input logic [31:0] base,
                      input int dly, input bit mem, input int lat);
    logic [255:0] l;
    int k;
    l = mk(base);
    delay = dly;
    if (mem)
      for (int i = 0; i < 8; i++) exp_addr.push_back(base + 32'(4*i));
    exp_line.push_back(l);
    request(la);
    wait_valid(k);
    chk("latency", 256'(k), 256'(lat));
    last_line = l;
  endtask

  initial begin
    int k;
    bus.ADDR_FROM_L1       = '0;
    bus.ADDR_FROM_L1_VALID = 1'b0;

    #3 RSTN = 1'b0;
    #1;
    chk("rst_valid", bus.DATA_TO_L1_VALID, 0);
    chk("rst_req", bus.MEM_RD_REQ, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_addr", bus.MEM_RD_ADDR, 0);
    chk("rst_data", bus.DATA_TO_L1, 0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    // line 0x40 -> byte base 0x800
    fill(27'h40, 32'h800, 0, 1'b1, 9);
    fill(27'h40, 32'h800, 3, 1'b1, 33);

    // stray requests during FETCH and during the RESP cycle
    delay = 0;
    for (int i = 0; i < 8; i++) exp_addr.push_back(32'h800 + 32'(4*i));
    exp_line.push_back(mk(32'h800));
    request(27'h40);
    repeat (2) @(negedge CLK);
    bus.ADDR_FROM_L1       = 27'h55;
    bus.ADDR_FROM_L1_VALID = 1'b1;
    @(negedge CLK);
    bus.ADDR_FROM_L1_VALID = 1'b0;
    wait_valid(k);
    chk("valid_seen", bus.DATA_TO_L1_VALID, 1);
    bus.ADDR_FROM_L1_VALID = 1'b1;
    @(negedge CLK);
    bus.ADDR_FROM_L1_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    #2;
    chk("busy_after_stray", bus.BUSY, 0);
    chk("addr_q_empty", 256'(exp_addr.size()), 0);

    // reset after beat-4 ack, line 0x48 -> 0x900
    for (int i = 0; i < 8; i++) exp_addr.push_back(32'h900 + 32'(4*i));
    exp_line.push_back(mk(32'h900));
    request(27'h48);
    repeat (5) @(posedge CLK);
    #2 RSTN = 1'b0;
    #1;
    chk("midrst_req", bus.MEM_RD_REQ, 0);
    chk("midrst_busy", bus.BUSY, 0);
    chk("midrst_valid", bus.DATA_TO_L1_VALID, 0);
    chk("midrst_data", bus.DATA_TO_L1, 0);
    chk("midrst_beats_done", 256'(exp_addr.size()), 3);
    exp_addr.delete();
    exp_line.delete();
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    fill(27'h13, 32'h260, 0, 1'b1, 9);

    // repeat request; hit path only with the line buffer
    fill(27'h40, 32'h800, 0, 1'b1, 9);
`ifdef L2_LINE_BUFFER_EN
    fill(27'h40, 32'h800, 0, 1'b0, 1);
`else
    fill(27'h40, 32'h800, 0, 1'b1, 9);
`endif
    fill(27'h41, 32'h820, 0, 1'b1, 9);

    // spurious ack while idle
    @(negedge CLK);
    spur = 1'b1;
    @(negedge CLK);
    spur = 1'b0;
    #2;
    chk("spur_busy", bus.BUSY, 0);
    chk("spur_req", bus.MEM_RD_REQ, 0);
    chk("spur_data", bus.DATA_TO_L1, last_line);
    repeat (4) @(negedge CLK);
    #2;
    chk("spur_valid", bus.DATA_TO_L1_VALID, 0);
    chk("final_addr_q", 256'(exp_addr.size()), 0);
    chk("final_line_q", 256'(exp_line.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
